// File: rtl/fpmul_txn_initiator_if.sv
// Request/response channel between the FP multiply initiator and its responder.
// master: drives req_valid/req_a/req_b/rsp_ready; slave: drives req_ready/rsp_valid/rsp_data.
interface fpmul_txn_initiator_if #(
   parameter int WIDTH = 32
) ();
   logic             req_valid;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             req_ready;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_ready;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/fpmul_txn_initiator.sv
// Initiator for the FP multiplier wrapper: operand FIFO -> one request at a time -> result FIFO.
// Ports: clk/rst, host op_wr/op_a/op_b/op_full/op_drop, bus (master), res_rd/res_data/res_empty, busy, txn_count.
module fpmul_txn_initiator #(
   parameter int WIDTH     = 32,
   parameter int OP_DEPTH  = 8,
   parameter int RES_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  op_wr,
   input  logic [WIDTH-1:0]      op_a,
   input  logic [WIDTH-1:0]      op_b,
   output logic                  op_full,
   output logic                  op_drop,
   fpmul_txn_initiator_if.master bus,
   input  logic                  res_rd,
   output logic [WIDTH-1:0]      res_data,
   output logic                  res_empty,
   output logic                  busy,
   output logic [15:0]           txn_count
);

   localparam int OAW = $clog2(OP_DEPTH);
   localparam int RAW = $clog2(RES_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t           state;
   logic [OAW:0]     op_wp, op_rp;
   logic [RAW:0]     res_wp, res_rp;
   logic [WIDTH-1:0] op_mem_a [OP_DEPTH];
   logic [WIDTH-1:0] op_mem_b [OP_DEPTH];
   logic [WIDTH-1:0] res_mem  [RES_DEPTH];

   logic             req_valid_q, rsp_ready_q;
   logic [WIDTH-1:0] req_a_q, req_b_q;

   logic op_empty, res_full;
   logic issue, op_push, rsp_fire, res_pop;

   // Extra pointer bit distinguishes full from empty.
   assign op_empty  = (op_wp == op_rp);
   assign op_full   = (op_wp[OAW] != op_rp[OAW]) &&
                      (op_wp[OAW-1:0] == op_rp[OAW-1:0]);
   assign res_empty = (res_wp == res_rp);
   assign res_full  = (res_wp[RAW] != res_rp[RAW]) &&
                      (res_wp[RAW-1:0] == res_rp[RAW-1:0]);

   // Issue only with result space reserved, so the RESP push never overflows.
   assign issue    = (state == IDLE) && !op_empty && !res_full;
   // A push into a full FIFO is still taken when the head leaves the same cycle.
   assign op_push  = op_wr && (!op_full || issue);
   assign rsp_fire = (state == RESP) && bus.rsp_valid && rsp_ready_q;
   assign res_pop  = res_rd && !res_empty;

   assign res_data      = res_mem[res_rp[RAW-1:0]];
   assign bus.req_valid = req_valid_q;
   assign bus.req_a     = req_a_q;
   assign bus.req_b     = req_b_q;
   assign bus.rsp_ready = rsp_ready_q;

   always_ff @(posedge clk) begin
      if (op_push) begin
         op_mem_a[op_wp[OAW-1:0]] <= op_a;
         op_mem_b[op_wp[OAW-1:0]] <= op_b;
      end
      if (rsp_fire)
         res_mem[res_wp[RAW-1:0]] <= bus.rsp_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         op_wp       <= '0;
         op_rp       <= '0;
         res_wp      <= '0;
         res_rp      <= '0;
         req_valid_q <= 1'b0;
         rsp_ready_q <= 1'b0;
         req_a_q     <= '0;
         req_b_q     <= '0;
         busy        <= 1'b0;
         op_drop     <= 1'b0;
         txn_count   <= '0;
      end else begin
         if (op_push)
            op_wp <= op_wp + 1'b1;
         if (op_wr && !op_push)
            op_drop <= 1'b1;
         if (res_pop)
            res_rp <= res_rp + 1'b1;

         unique case (state)
            IDLE: begin
               if (issue) begin
                  req_a_q     <= op_mem_a[op_rp[OAW-1:0]];
                  req_b_q     <= op_mem_b[op_rp[OAW-1:0]];
                  op_rp       <= op_rp + 1'b1;
                  req_valid_q <= 1'b1;
                  busy        <= 1'b1;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (bus.req_ready) begin
                  req_valid_q <= 1'b0;
                  rsp_ready_q <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_fire) begin
                  res_wp      <= res_wp + 1'b1;
                  rsp_ready_q <= 1'b0;
                  txn_count   <= txn_count + 16'd1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpmul_txn_initiator.sv
// Directed bench for fpmul_txn_initiator with a hand-driven responder.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_fpmul_txn_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_wr;
   logic [31:0] op_a, op_b;
   logic        op_full, op_drop;
   logic        res_rd;
   logic [31:0] res_data;
   logic        res_empty, busy;
   logic [15:0] txn_count;

   int checks = 0;
   int errors = 0;

   fpmul_txn_initiator_if #(.WIDTH(32)) bus ();

   fpmul_txn_initiator #(
      .WIDTH(32), .OP_DEPTH(8), .RES_DEPTH(8)
   ) dut (
      .clk(clk), .rst(rst),
      .op_wr(op_wr), .op_a(op_a), .op_b(op_b),
      .op_full(op_full), .op_drop(op_drop),
      .bus(bus),
      .res_rd(res_rd), .res_data(res_data), .res_empty(res_empty),
      .busy(busy), .txn_count(txn_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, " req_valid"}, 32'(bus.req_valid), 32'd0);
      chk({pfx, " rsp_ready"}, 32'(bus.rsp_ready), 32'd0);
      chk({pfx, " busy"},      32'(busy),          32'd0);
      chk({pfx, " op_drop"},   32'(op_drop),       32'd0);
      chk({pfx, " txn_count"}, 32'(txn_count),     32'd0);
      chk({pfx, " req_a"},     bus.req_a,          32'd0);
      chk({pfx, " req_b"},     bus.req_b,          32'd0);
      chk({pfx, " op_full"},   32'(op_full),       32'd0);
      chk({pfx, " res_empty"}, 32'(res_empty),     32'd1);
   endtask

   initial begin
      rst = 1'b1; op_wr = 1'b0; op_a = '0; op_b = '0; res_rd = 1'b0;
      bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0;
      step(); step();
      rst = 1'b0;
      chk_reset("reset");

      // Single transaction with a stalled responder
      op_wr = 1'b1; op_a = 32'h4040_0000; op_b = 32'h4000_0000;
      step();
      op_wr = 1'b0;
      chk("lat t+1 req_valid", 32'(bus.req_valid), 32'd0);
      step();
      chk("lat t+2 req_valid", 32'(bus.req_valid), 32'd1);
      chk("busy in REQ", 32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("stall req_valid", 32'(bus.req_valid), 32'd1);
         chk("stall req_a", bus.req_a, 32'h4040_0000);
         chk("stall req_b", bus.req_b, 32'h4000_0000);
         chk("stall rsp_ready", 32'(bus.rsp_ready), 32'd0);
         step();
      end
      bus.req_ready = 1'b1;
      step();
      bus.req_ready = 1'b0;
      chk("post-hs req_valid", 32'(bus.req_valid), 32'd0);
      chk("post-hs rsp_ready", 32'(bus.rsp_ready), 32'd1);
      step();
      chk("one handshake", 32'(bus.req_valid), 32'd0);
      bus.rsp_valid = 1'b1; bus.rsp_data = 32'h40C0_0000;
      step();
      bus.rsp_valid = 1'b0;
      chk("single res_empty", 32'(res_empty), 32'd0);
      chk("single res_data", res_data, 32'h40C0_0000);
      chk("single txn_count", 32'(txn_count), 32'd1);
      chk("single busy", 32'(busy), 32'd0);
      chk("single rsp_ready", 32'(bus.rsp_ready), 32'd0);
      res_rd = 1'b1;
      step();
      res_rd = 1'b0;
      chk("pop res_empty", 32'(res_empty), 32'd1);

      // Spurious response while IDLE; also a read of an empty result FIFO
      bus.rsp_valid = 1'b1; bus.rsp_data = 32'hDEAD_BEEF; res_rd = 1'b1;
      step(); step();
      bus.rsp_valid = 1'b0; res_rd = 1'b0;
      chk("spur txn_count", 32'(txn_count), 32'd1);
      chk("spur res_empty", 32'(res_empty), 32'd1);
      chk("spur busy", 32'(busy), 32'd0);

      // Operand overflow: 9 pairs, first goes to REQ, 8 stay queued
      for (int i = 1; i <= 9; i++) begin
         op_wr = 1'b1; op_a = 32'(i); op_b = 32'(i + 100);
         step();
      end
      op_wr = 1'b0;
      chk("ovf op_full", 32'(op_full), 32'd1);
      chk("ovf op_drop", 32'(op_drop), 32'd0);
      chk("ovf req_valid", 32'(bus.req_valid), 32'd1);
      chk("ovf req_a", bus.req_a, 32'd1);
      op_wr = 1'b1; op_a = 32'd10; op_b = 32'd110;
      step();
      op_wr = 1'b0;
      chk("drop op_drop", 32'(op_drop), 32'd1);
      chk("drop op_full", 32'(op_full), 32'd1);

      // Serve 8 transactions without reading results
      for (int i = 1; i <= 8; i++) begin
         chk("serve req_valid", 32'(bus.req_valid), 32'd1);
         chk("serve req_a", bus.req_a, 32'(i));
         chk("serve req_b", bus.req_b, 32'(i + 100));
         bus.req_ready = 1'b1;
         step();
         bus.req_ready = 1'b0;
         bus.rsp_valid = 1'b1; bus.rsp_data = 32'h3F80_0000 + 32'(i);
         step();
         bus.rsp_valid = 1'b0;
         step();
      end
      chk("bp req_valid", 32'(bus.req_valid), 32'd0);
      chk("bp busy", 32'(busy), 32'd0);
      chk("bp txn_count", 32'(txn_count), 32'd9);
      chk("bp op_full", 32'(op_full), 32'd0);
      chk("bp res_data", res_data, 32'h3F80_0001);
      step(); step();
      chk("bp hold req_valid", 32'(bus.req_valid), 32'd0);
      chk("sticky op_drop", 32'(op_drop), 32'd1);
      res_rd = 1'b1;
      step();
      res_rd = 1'b0;
      chk("bp pop req_valid", 32'(bus.req_valid), 32'd0);
      chk("bp pop res_data", res_data, 32'h3F80_0002);
      step();
      chk("bp issue req_valid", 32'(bus.req_valid), 32'd1);
      chk("bp issue req_a", bus.req_a, 32'd9);
      chk("bp issue req_b", bus.req_b, 32'd109);

      // Reset during RESP with a product on the bus
      bus.req_ready = 1'b1;
      step();
      bus.req_ready = 1'b0;
      chk("pre-rst rsp_ready", 32'(bus.rsp_ready), 32'd1);
      bus.rsp_valid = 1'b1; bus.rsp_data = 32'h4120_0000; rst = 1'b1;
      step();
      rst = 1'b0; bus.rsp_valid = 1'b0;
      chk_reset("midrst");
      step(); step();
      chk("post-rst res_empty", 32'(res_empty), 32'd1);
      chk("post-rst req_valid", 32'(bus.req_valid), 32'd0);
      chk("post-rst txn_count", 32'(txn_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpmul_txn_initiator.md
Name: fpmul_txn_initiator

Overview:
- Initiator end of the operand/result valid-ready protocol of the FP multiplier wrapper; the wrapper is the responder.
- Buffers operand pairs (A,B) written by the host in an operand FIFO.
- Issues one multiply transaction at a time on the request channel and collects each product from the response channel.
- Stores products in a result FIFO for the host to read.

Parameters:
- WIDTH, 32, operand/result width (IEEE-754 single).
- OP_DEPTH, 8, operand FIFO entries (power of 2, ≥2).
- RES_DEPTH, 8, result FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- op_wr  in  1  push operand pair
- op_a  in  WIDTH  operand A to push
- op_b  in  WIDTH  operand B to push
- op_full  out  1  operand FIFO full
- op_drop  out  1  sticky: push attempted while full
- req_valid  out  1  request valid (to responder input-side valid)
- req_a  out  WIDTH  operand A to responder
- req_b  out  WIDTH  operand B to responder
- req_ready  in  1  responder ready to accept operands
- rsp_valid  in  1  responder product valid
- rsp_data  in  WIDTH  responder product
- rsp_ready  out  1  initiator ready to accept product
- res_rd  in  1  pop result
- res_data  out  WIDTH  head of result FIFO (show-ahead)
- res_empty  out  1  result FIFO empty
- busy  out  1  transaction outstanding (state ≠ IDLE)
- txn_count  out  16  completed transactions, wraps 0xFFFF→0

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - req_valid=0, rsp_ready=0, busy=0, op_drop=0, txn_count=0.
  - req_a=0, req_b=0.
  - Both FIFOs emptied: op_full=0, res_empty=1.
  - FSM=IDLE.
- Reset asserted mid-transaction aborts it; any in-flight product is discarded.
- All outputs are registered except res_data, op_full and res_empty, which are driven from FIFO state registers.
- FSM states:
  - IDLE:
    - Operand FIFO non-empty and result FIFO not full → pop head pair into req_a/req_b, req_valid<=1, →REQ.
    - Otherwise stay.
  - REQ:
    - req_valid stays 1 and req_a/req_b are held stable until req_valid&&req_ready.
    - On that cycle: req_valid<=0, rsp_ready<=1, →RESP.
  - RESP:
    - On rsp_valid&&rsp_ready: push rsp_data into result FIFO, rsp_ready<=0, txn_count+=1, →IDLE.
    - rsp_valid seen in IDLE or REQ is ignored (rsp_ready=0).
- At most one outstanding transaction; issue requires result-FIFO space, so the push in RESP never overflows.
- Latency: op_wr at cycle t into an empty FIFO → req_valid high at t+2 (count visible at t+1, IDLE issues at t+1, register at t+2).
- Back-to-back: the next request may issue the cycle after returning to IDLE.
- Operand FIFO:
  - op_wr while op_full → pair dropped, op_drop<=1 (sticky until rst).
  - op_wr while full and the IDLE pop occur in the same cycle → write accepted (count unchanged).
  - Simultaneous push/pop when not full → count unchanged.
- Result FIFO:
  - res_rd while res_empty → ignored, no pointer change.
  - Simultaneous RESP push and res_rd → both occur.
  - A pop that frees the last slot is visible to IDLE the next cycle.
- Pointers wrap modulo depth; full/empty use an extra pointer bit.

Test Plan:
- Single txn: push A=0x40400000, B=0x40000000; responder model returns 0x40C00000 → req_valid at t+2 with those operands; result 0x40C00000 on res_data; txn_count=1; busy returns 0.
- Stalled responder: req_ready held 0 for 5 cycles → req_valid, req_a, req_b stable for all 5; one handshake only; rsp_ready rises the cycle after the handshake.
- Operand overflow: push 9 pairs back-to-back, req_ready=0 → first pops into REQ, FIFO holds 8, op_full=1, nothing dropped; push a 10th → op_drop=1, remains 1 until rst.
- Result backpressure: 8 txns with no res_rd → res FIFO full, FSM stays IDLE with operands pending; one res_rd → next request issues 1 cycle later.
- Reset mid-RESP: assert rst with rsp_ready=1 and rsp_valid=1 → next cycle all outputs at reset values, res_empty=1, no product stored, txn_count=0.
- Spurious response: rsp_valid=1 while IDLE → ignored, txn_count unchanged, res_empty stays 1.
